// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage definitions: FSM states, default vectors and the
// next-PC source encoding used between the selector and the PC register.
package mips_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_SEQ   = 2'd1,
    SEL_REDIR = 2'd2,
    SEL_EXC   = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch-PC control and result bundle between the pipeline and pc_gen_unit.
interface pc_gen_unit_if #(
  parameter int PC_W = 32
);

  logic            i_stall;
  logic            i_fetch_ready;
  logic            i_redir_valid;
  logic [PC_W-1:0] i_redir_pc;
  logic            i_exc;
  logic            i_halt;
  logic            i_resume;
  logic [PC_W-1:0] o_pc;
  logic [PC_W-1:0] o_pc_plus;
  logic            o_valid;
  logic [PC_W-1:0] o_epc;
  logic            o_misalign;

  // PC generator side
  modport master (
    input  i_stall, i_fetch_ready, i_redir_valid, i_redir_pc,
           i_exc, i_halt, i_resume,
    output o_pc, o_pc_plus, o_valid, o_epc, o_misalign
  );

  // Pipeline / control side
  modport slave (
    output i_stall, i_fetch_ready, i_redir_valid, i_redir_pc,
           i_exc, i_halt, i_resume,
    input  o_pc, o_pc_plus, o_valid, o_epc, o_misalign
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: exception, misaligned-redirect trap,
// redirect, hold, sequential. Also yields the EPC load and misalign flag.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int              PC_W    = 32,
  parameter logic [PC_W-1:0] EXC_VEC = PC_W'(DEF_EXC_VEC),
  parameter int              ALIGN_B = 2
) (
  input  pc_state_e       state,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] pc_plus,
  input  logic            exc,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc,
  input  logic            halt,
  input  logic            stall,
  input  logic            fetch_ready,
  output pc_sel_e         sel,
  output logic [PC_W-1:0] pc_d,
  output logic            epc_load,
  output logic [PC_W-1:0] epc_val,
  output logic            misalign
);

  // Mask form keeps ALIGN_B = 0 (byte-addressed fetch) legal.
  localparam logic [PC_W-1:0] ALIGN_MASK = (PC_W'(1) << ALIGN_B) - PC_W'(1);

  logic redir_misaligned;

  assign redir_misaligned = |(redir_pc & ALIGN_MASK);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sel      = SEL_HOLD;
    epc_load = 1'b0;
    epc_val  = pc;
    misalign = 1'b0;

    case (state)
      ST_RUN: begin
        if (exc) begin
          sel      = SEL_EXC;
          epc_load = 1'b1;
        end else if (redir_valid && redir_misaligned) begin
          sel      = SEL_EXC;
          epc_load = 1'b1;
          epc_val  = redir_pc;
          misalign = 1'b1;
        end else if (redir_valid) begin
          sel = SEL_REDIR;
        end else if (halt || stall || !fetch_ready) begin
          sel = SEL_HOLD;
        end else begin
          sel = SEL_SEQ;
        end
      end
      ST_HALT: begin
        // Redirects are dropped while halted; only an exception moves the PC.
        if (exc) begin
          sel      = SEL_EXC;
          epc_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d = pc;
    case (sel)
      SEL_SEQ:   pc_d = pc_plus;
      SEL_REDIR: pc_d = redir_pc;
      SEL_EXC:   pc_d = EXC_VEC;
      default:   pc_d = pc;
    endcase
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator: BOOT/RUN/HALT FSM, PC, EPC and the
// one-cycle misaligned-target pulse. Next-PC selection lives in pc_next_sel.
module pc_gen_unit
  import mips_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(DEF_EXC_VEC),
  parameter int              INC       = 4,
  parameter int              ALIGN_B   = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pc_gen_unit_if.master bus
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            misalign_q, misalign_d;

  logic [PC_W-1:0] pc_plus;
  pc_sel_e         sel;
  logic [PC_W-1:0] sel_pc;
  logic            epc_load;
  logic [PC_W-1:0] epc_val;
  logic            sel_misalign;

  // Addition truncates to PC_W, so the top of the address space wraps to 0.
  assign pc_plus = pc_q + PC_W'(INC);

  pc_next_sel #(
    .PC_W    (PC_W),
    .EXC_VEC (EXC_VEC),
    .ALIGN_B (ALIGN_B)
  ) u_next_sel (
    .state       (state_q),
    .pc          (pc_q),
    .pc_plus     (pc_plus),
    .exc         (bus.i_exc),
    .redir_valid (bus.i_redir_valid),
    .redir_pc    (bus.i_redir_pc),
    .halt        (bus.i_halt),
    .stall       (bus.i_stall),
    .fetch_ready (bus.i_fetch_ready),
    .sel         (sel),
    .pc_d        (sel_pc),
    .epc_load    (epc_load),
    .epc_val     (epc_val),
    .misalign    (sel_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = sel_pc;
    epc_d      = epc_load ? epc_val : epc_q;
    misalign_d = sel_misalign;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // Halt only takes effect when no flush claimed the cycle.
        if (sel == SEL_HOLD && bus.i_halt) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (bus.i_exc || bus.i_resume) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.o_pc       = pc_q;
  assign bus.o_pc_plus  = pc_plus;
  assign bus.o_valid    = (state_q == ST_RUN);
  assign bus.o_epc      = epc_q;
  assign bus.o_misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: a reference model of the fetch-PC rules is
// compared every cycle, plus literal expectations from the boot/stall/redirect
// /trap/halt/wrap/reset scenarios.
module tb_pc_gen_unit;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0180;
  localparam int          INC       = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   run_cmp;

  pc_gen_unit_if #(.PC_W(32)) bus ();

  pc_gen_unit #(
    .PC_W      (32),
    .RESET_VEC (RESET_VEC),
    .EXC_VEC   (EXC_VEC),
    .INC       (INC),
    .ALIGN_B   (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 = booting, 1 = running, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_pc   = RESET_VEC;
      m_epc  = 32'h0;
      m_mis  = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (bus.i_exc) begin
          m_epc = m_pc;
          m_pc  = EXC_VEC;
        end else if (bus.i_redir_valid && (bus.i_redir_pc % INC) != 0) begin
          m_epc = bus.i_redir_pc;
          m_pc  = EXC_VEC;
          m_mis = 1'b1;
        end else if (bus.i_redir_valid) begin
          m_pc = bus.i_redir_pc;
        end else if (bus.i_halt) begin
          m_mode = 2;
        end else if (!bus.i_stall && bus.i_fetch_ready) begin
          m_pc = 32'((64'(m_pc) + 64'(INC)) % 64'h1_0000_0000);
        end
      end else begin
        if (bus.i_exc) begin
          m_epc  = m_pc;
          m_pc   = EXC_VEC;
          m_mode = 1;
        end else if (bus.i_resume) begin
          m_mode = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_pc",       bus.o_pc, m_pc);
      check("cmp_pc_plus",  bus.o_pc_plus, 32'((64'(m_pc) + 64'(INC)) % 64'h1_0000_0000));
      check("cmp_valid",    32'(bus.o_valid), 32'(m_mode == 1));
      check("cmp_epc",      bus.o_epc, m_epc);
      check("cmp_misalign", 32'(bus.o_misalign), 32'(m_mis));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.i_redir_valid = 1'b1;
    bus.i_redir_pc    = target;
    cyc();
    bus.i_redir_valid = 1'b0;
    bus.i_redir_pc    = 32'h0;
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    run_cmp            = 1'b0;
    rst_n              = 1'b0;
    bus.i_stall        = 1'b0;
    bus.i_fetch_ready  = 1'b1;
    bus.i_redir_valid  = 1'b0;
    bus.i_redir_pc     = 32'h0;
    bus.i_exc          = 1'b0;
    bus.i_halt         = 1'b0;
    bus.i_resume       = 1'b0;
    #1;
    run_cmp = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // 1 Boot
    check("reset_pc", bus.o_pc, RESET_VEC);
    check("reset_epc", bus.o_epc, 32'h0);
    rst_n = 1'b1;
    check("boot_pc", bus.o_pc, 32'h0);
    check("boot_valid", 32'(bus.o_valid), 32'h0);
    cyc();
    check("run0_pc", bus.o_pc, 32'h0);
    check("run0_valid", 32'(bus.o_valid), 32'h1);
    cyc();
    check("run1_pc", bus.o_pc, 32'h4);
    cyc();
    check("run2_pc", bus.o_pc, 32'h8);
    repeat (2) cyc();
    check("at_10", bus.o_pc, 32'h10);

    // 2 Stall then back-pressure
    bus.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_hold", bus.o_pc, 32'h10);
    end
    bus.i_stall       = 1'b0;
    bus.i_fetch_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("bp_hold", bus.o_pc, 32'h10);
    end
    bus.i_fetch_ready = 1'b1;
    cyc();
    check("after_hold", bus.o_pc, 32'h14);

    // 3 Redirect beats stall; exception beats redirect
    redirect(32'h20);
    check("redir_20", bus.o_pc, 32'h20);
    bus.i_stall = 1'b1;
    redirect(32'h400);
    check("redir_stall", bus.o_pc, 32'h400);
    redirect(32'h20);
    bus.i_exc = 1'b1;
    redirect(32'h400);
    bus.i_exc   = 1'b0;
    bus.i_stall = 1'b0;
    check("exc_pc", bus.o_pc, EXC_VEC);
    check("exc_epc", bus.o_epc, 32'h20);

    // 4 Misaligned redirect target
    redirect(32'h402);
    check("mis_pc", bus.o_pc, 32'h8000_0180);
    check("mis_epc", bus.o_epc, 32'h402);
    check("mis_pulse", 32'(bus.o_misalign), 32'h1);
    cyc();
    check("mis_clear", 32'(bus.o_misalign), 32'h0);
    check("mis_next_pc", bus.o_pc, 32'h8000_0184);

    // 5 Halt / resume / exception in halt
    redirect(32'h30);
    bus.i_halt = 1'b1;
    cyc();
    bus.i_halt = 1'b0;
    check("halt_valid", 32'(bus.o_valid), 32'h0);
    check("halt_pc", bus.o_pc, 32'h30);
    redirect(32'h500);
    check("halt_redir_ign", bus.o_pc, 32'h30);
    bus.i_resume = 1'b1;
    cyc();
    bus.i_resume = 1'b0;
    check("resume_valid", 32'(bus.o_valid), 32'h1);
    check("resume_pc", bus.o_pc, 32'h30);
    cyc();
    check("resume_next", bus.o_pc, 32'h34);
    bus.i_halt = 1'b1;
    cyc();
    bus.i_halt = 1'b0;
    check("halt2_valid", 32'(bus.o_valid), 32'h0);
    bus.i_exc    = 1'b1;
    bus.i_resume = 1'b1;
    cyc();
    bus.i_exc    = 1'b0;
    bus.i_resume = 1'b0;
    check("halt_exc_pc", bus.o_pc, EXC_VEC);
    check("halt_exc_epc", bus.o_epc, 32'h34);
    check("halt_exc_valid", 32'(bus.o_valid), 32'h1);

    // 6 Wrap and mid-run reset
    redirect(32'hFFFF_FFFC);
    check("top_pc", bus.o_pc, 32'hFFFF_FFFC);
    check("top_pc_plus", bus.o_pc_plus, 32'h0);
    cyc();
    check("wrap_pc", bus.o_pc, 32'h0);
    repeat (2) cyc();
    check("pre_rst_pc", bus.o_pc, 32'h8);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", bus.o_pc, RESET_VEC);
    check("mid_rst_valid", 32'(bus.o_valid), 32'h0);
    check("mid_rst_epc", bus.o_epc, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("reboot_pc", bus.o_pc, RESET_VEC);
    check("reboot_valid", 32'(bus.o_valid), 32'h1);
    cyc();
    check("reboot_next", bus.o_pc, 32'h4);

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
